// File: rtl/ahb_pkg.sv
// Shared AHB burst-generator types and the next-beat address function.
package ahb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BPB     = DATA_W / 8;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } ahb_op_t;

  typedef enum logic {
    BURST_INCR = 1'b0,
    BURST_WRAP = 1'b1
  } ahb_incr_type_t;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } ahb_trans_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } ahb_state_t;

  typedef struct packed {
    ahb_op_t           op;
    ahb_incr_type_t    incr;
    logic [ADDR_W-1:0] addr;
    logic [BPB-1:0]    byte_sel;
    logic [LEN_W-1:0]  len;
  } ahb_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    ahb_trans_t        trans;
    logic [BPB-1:0]    byte_sel;
    logic              first;
    logic              last;
  } ahb_beat_t;

  // Next beat address: align, step one beat, wrap on len*bpb when len is a power of two.
  function automatic logic [ADDR_W-1:0] ahb_next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [LEN_W-1:0]  len,
    input ahb_incr_type_t    kind,
    input int unsigned       bpb
  );
    logic [ADDR_W-1:0] w_bpb;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;
    w_bpb     = ADDR_W'(bpb);
    w_aligned = addr & ~(w_bpb - ADDR_W'(1));
    w_inc     = w_aligned + w_bpb;
    w_mask    = (ADDR_W'(len) * w_bpb) - ADDR_W'(1);
    if ((kind == BURST_WRAP) && ((len & (len - LEN_W'(1))) == '0)) begin
      return (w_aligned & ~w_mask) | (w_inc & w_mask);
    end
    return w_inc;
  endfunction

endpackage

// File: rtl/ahb_req_fifo.sv
// Request queue: power-of-two depth, head entry presented straight from storage,
// full/empty flags held in registers.
module ahb_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_do_push   = i_push && !r_full;
  assign w_do_pop    = i_pop && !r_empty;
  assign w_count_nxt = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  // Storage write; contents need no reset since the flags gate every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/ahb_burst_gen.sv
// AHB burst generator: queues requests and expands each into len address beats.
module ahb_burst_gen
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req_valid,
  output logic      req_ready,
  input  ahb_req_t  req,
  output logic      beat_valid,
  input  logic      beat_ready,
  output ahb_beat_t beat,
  output logic      busy,
  output logic      err_len
);

  localparam int unsigned BPB    = DATA_W / 8;
  localparam int unsigned REQ_W  = $bits(ahb_req_t);
  localparam int unsigned LW     = ahb_pkg::LEN_W;
  localparam int unsigned PKG_AW = ahb_pkg::ADDR_W;

  ahb_state_t        r_state;
  ahb_state_t        w_state_nxt;
  ahb_beat_t         r_beat;
  logic              r_beat_valid;
  logic [LW-1:0]     r_remain;
  logic [LW-1:0]     r_len;
  ahb_incr_type_t    r_kind;
  logic              r_err_len;
  logic              r_rdy_en;
  ahb_req_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_bad_len;
  logic              w_push;
  logic              w_pop;
  logic              w_step;
  logic              w_done;
  logic              w_fire;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_accept    = req_valid && req_ready;
  assign w_bad_len   = (req.len == '0) || (32'(req.len) > MAX_LEN);
  assign w_push      = w_accept && !w_bad_len;
  assign w_fire      = r_beat_valid && beat_ready;
  assign w_next_addr = ADDR_W'(ahb_next_addr(r_beat.addr, r_len, r_kind, BPB));

  ahb_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (req),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: start on a queued request, chain bursts without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_BURST;
      ST_BURST: if (w_fire && r_beat.last && w_empty) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath controls: pop a new head, step within a burst, or retire.
  always_comb begin
    w_pop  = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_BURST: begin
        if (w_fire) begin
          if (!r_beat.last)  w_step = 1'b1;
          else if (!w_empty) w_pop  = 1'b1;
          else               w_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Beat register: held whenever the current beat is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat       <= '0;
      r_beat_valid <= 1'b0;
      r_remain     <= '0;
      r_len        <= '0;
      r_kind       <= BURST_INCR;
    end else if (w_pop) begin
      r_beat.addr     <= w_head.addr;
      r_beat.write    <= (w_head.op == OP_WRITE);
      r_beat.trans    <= TRANS_NONSEQ;
      r_beat.byte_sel <= w_head.byte_sel;
      r_beat.first    <= 1'b1;
      r_beat.last     <= (w_head.len == LW'(1));
      r_beat_valid    <= 1'b1;
      r_remain        <= w_head.len - LW'(1);
      r_len           <= w_head.len;
      r_kind          <= w_head.incr;
    end else if (w_step) begin
      r_beat.addr  <= PKG_AW'(w_next_addr);
      r_beat.trans <= TRANS_SEQ;
      r_beat.first <= 1'b0;
      r_beat.last  <= (r_remain == LW'(1));
      r_remain     <= r_remain - LW'(1);
    end else if (w_done) begin
      r_beat_valid <= 1'b0;
    end
  end

  // Length-error pulse and post-reset request enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_len <= 1'b0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_err_len <= w_accept && w_bad_len;
      r_rdy_en  <= 1'b1;
    end
  end

  assign req_ready  = r_rdy_en && !w_full;
  assign beat       = r_beat;
  assign beat_valid = r_beat_valid;
  assign busy       = !w_empty || (r_state == ST_BURST);
  assign err_len    = r_err_len;

endmodule

// File: tb/tb_ahb_burst_gen.sv
// Scoreboard bench for ahb_burst_gen with directed request vectors.
module tb_ahb_burst_gen;
  import ahb_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      req_valid;
  logic      req_ready;
  ahb_req_t  req;
  logic      beat_valid;
  logic      beat_ready;
  ahb_beat_t beat;
  logic      busy;
  logic      err_len;

  int        checks;
  int        errors;
  int        err_seen;
  int        cyc;
  ahb_beat_t exp_q[$];
  int        fire_cyc[$];
  logic      prev_stall;
  ahb_beat_t prev_beat;

  ahb_burst_gen #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_LEN (8),
    .DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req        (req),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat       (beat),
    .busy       (busy),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic ahb_beat_t mk(input logic [31:0] a, input ahb_trans_t t, input logic w,
                                   input logic [3:0] bs, input logic f, input logic l);
    ahb_beat_t b;
    b.addr = a; b.write = w; b.trans = t; b.byte_sel = bs; b.first = f; b.last = l;
    return b;
  endfunction

  task automatic send_req(input ahb_op_t op, input ahb_incr_type_t k, input logic [31:0] a,
                          input logic [3:0] bs, input logic [3:0] len);
    logic acc;
    int   n;
    req.op = op; req.incr = k; req.addr = a; req.byte_sel = bs; req.len = len;
    req_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) chk("req_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int   base;
    int   idx;
    int   err0;
    logic acc;
    ahb_beat_t zero_beat;

    checks = 0; errors = 0; err_seen = 0;
    prev_stall = 1'b0; prev_beat = '0;
    rst_n = 1'b0; req_valid = 1'b0; req = '0; beat_ready = 1'b1;
    zero_beat = '0;

    // Monitor: pops the scoreboard on every accepted beat, checks stall stability.
    fork
      begin
        ahb_beat_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (err_len) err_seen++;
            if (beat_valid && prev_stall) chk("beat_stable", 64'(beat), 64'(prev_beat));
            if (beat_valid && beat_ready) begin
              fire_cyc.push_back(cyc);
              if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(beat.addr), 64'hFFFF_FFFF_FFFF_FFFF);
              end else begin
                e = exp_q.pop_front();
                chk("beat", 64'(beat), 64'(e));
              end
            end
            prev_stall = beat_valid && !beat_ready;
            prev_beat  = beat;
          end else begin
            prev_stall = 1'b0;
          end
        end
      end
    join_none

    // Reset values
    #12;
    chk("rst_beat_valid", 64'(beat_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_len", 64'(err_len), 64'(0));
    chk("rst_beat", 64'(beat), 64'(zero_beat));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 64'(req_ready), 64'(1));

    // INCR len 4 at 0x100, with one-cycle latency check
    exp_q.push_back(mk(32'h100, TRANS_NONSEQ, 1'b1, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h104, TRANS_SEQ,    1'b1, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h108, TRANS_SEQ,    1'b1, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h10C, TRANS_SEQ,    1'b1, 4'hF, 1'b0, 1'b1));
    send_req(OP_WRITE, BURST_INCR, 32'h100, 4'hF, 4'd4);
    chk("lat_edge_n", 64'(beat_valid), 64'(0));
    chk("busy_queued", 64'(busy), 64'(1));
    @(posedge clk); #1;
    chk("lat_edge_n1", 64'(beat_valid), 64'(1));
    wait_drain("incr4");

    // WRAP len 4 at 0x38
    exp_q.push_back(mk(32'h38, TRANS_NONSEQ, 1'b0, 4'h3, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h3C, TRANS_SEQ,    1'b0, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h30, TRANS_SEQ,    1'b0, 4'h3, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h34, TRANS_SEQ,    1'b0, 4'h3, 1'b0, 1'b1));
    send_req(OP_READ, BURST_WRAP, 32'h38, 4'h3, 4'd4);
    wait_drain("wrap4");

    // WRAP len 4 unaligned start, then WRAP len 3 (non power of two, behaves as INCR), op IDLE reads
    exp_q.push_back(mk(32'h3A, TRANS_NONSEQ, 1'b0, 4'hC, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h3C, TRANS_SEQ,    1'b0, 4'hC, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h30, TRANS_SEQ,    1'b0, 4'hC, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h34, TRANS_SEQ,    1'b0, 4'hC, 1'b0, 1'b1));
    send_req(OP_IDLE, BURST_WRAP, 32'h3A, 4'hC, 4'd4);
    exp_q.push_back(mk(32'h3C, TRANS_NONSEQ, 1'b0, 4'h1, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h40, TRANS_SEQ,    1'b0, 4'h1, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h44, TRANS_SEQ,    1'b0, 4'h1, 1'b0, 1'b1));
    send_req(OP_IDLE, BURST_WRAP, 32'h3C, 4'h1, 4'd3);
    wait_drain("wrap_odd");

    // INCR wrapping past the top of the address space
    exp_q.push_back(mk(32'hFFFF_FFFC, TRANS_NONSEQ, 1'b1, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h0000_0000, TRANS_SEQ,    1'b1, 4'hF, 1'b0, 1'b1));
    send_req(OP_WRITE, BURST_INCR, 32'hFFFF_FFFC, 4'hF, 4'd2);
    wait_drain("addr_rollover");

    // Two back-to-back len 2 requests: four consecutive beats
    base = fire_cyc.size();
    exp_q.push_back(mk(32'h200, TRANS_NONSEQ, 1'b1, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h204, TRANS_SEQ,    1'b1, 4'hF, 1'b0, 1'b1));
    exp_q.push_back(mk(32'h300, TRANS_NONSEQ, 1'b0, 4'hF, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h304, TRANS_SEQ,    1'b0, 4'hF, 1'b0, 1'b1));
    send_req(OP_WRITE, BURST_INCR, 32'h200, 4'hF, 4'd2);
    send_req(OP_READ,  BURST_INCR, 32'h300, 4'hF, 4'd2);
    wait_drain("b2b");
    chk("b2b_count", 64'(fire_cyc.size() - base), 64'(4));
    if (fire_cyc.size() >= base + 4)
      chk("b2b_no_bubble", 64'(fire_cyc[base+3] - fire_cyc[base]), 64'(3));

    // Length errors, then a single-beat request
    err0 = err_seen;
    send_req(OP_READ, BURST_INCR, 32'h40, 4'hF, 4'd0);
    chk("err0_pulse_now", 64'(err_len), 64'(1));
    @(posedge clk); #1;
    chk("err0_pulse_once", 64'(err_len), 64'(0));
    chk("err0_count", 64'(err_seen - err0), 64'(1));
    chk("err0_not_busy", 64'(busy), 64'(0));
    send_req(OP_READ, BURST_INCR, 32'h40, 4'hF, 4'd9);
    @(posedge clk); #1;
    chk("err9_count", 64'(err_seen - err0), 64'(2));
    chk("err9_not_busy", 64'(busy), 64'(0));
    exp_q.push_back(mk(32'h44, TRANS_NONSEQ, 1'b1, 4'h5, 1'b1, 1'b1));
    send_req(OP_WRITE, BURST_INCR, 32'h44, 4'h5, 4'd1);
    wait_drain("len1");
    chk("err_total", 64'(err_seen - err0), 64'(2));

    // Backpressure: DEPTH+1 accepted, then ready drops; beat held stable
    beat_ready = 1'b0;
    idx = 0;
    req.op = OP_READ; req.incr = BURST_INCR; req.byte_sel = 4'hF; req.len = 4'd1;
    req.addr = 32'h500;
    req_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(mk(32'h500 + 32'(idx) * 32'h10, TRANS_NONSEQ, 1'b0, 4'hF, 1'b1, 1'b1));
        idx++;
        req.addr = 32'h500 + 32'(idx) * 32'h10;
        if (idx == 6) begin
          req_valid = 1'b0;
          break;
        end
      end
      if (c == 20) begin
        chk("full_accepted", 64'(idx), 64'(5));
        chk("full_ready_low", 64'(req_ready), 64'(0));
        chk("full_beat_addr", 64'(beat.addr), 64'h500);
        beat_ready = 1'b1;
      end
    end
    req_valid = 1'b0;
    chk("full_all_accepted", 64'(idx), 64'(6));
    wait_drain("full");

    // Reset during the second beat of a len 8 burst
    exp_q.push_back(mk(32'h1000, TRANS_NONSEQ, 1'b0, 4'hF, 1'b1, 1'b0));
    send_req(OP_READ, BURST_INCR, 32'h1000, 4'hF, 4'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_beat2", 64'(beat.addr), 64'h1004);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(beat_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_quiet", 64'(beat_valid), 64'(0));
    chk("post_rst_sb", 64'(exp_q.size()), 64'(0));
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    exp_q.push_back(mk(32'h2000, TRANS_NONSEQ, 1'b1, 4'hF, 1'b1, 1'b1));
    send_req(OP_WRITE, BURST_INCR, 32'h2000, 4'hF, 4'd1);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_burst_gen.md
AHB_BURST_GEN -- requirements
Module: ahb_burst_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, beat width (32/64/128); BPB = DATA_W/8 bytes per beat.
REQ-003 The block SHALL have parameter MAX_LEN, default 8, maximum beats per request (power of two, 1..16).
REQ-004 The block SHALL have parameter DEPTH, default 4, request queue entries (power of two, >=2).
REQ-005 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have ports req_valid in 1, req_ready out 1  request handshake.
REQ-008 The block SHALL have port req in ahb_req_t  op, incr, addr[ADDR_W], byte_sel[BPB], len[$clog2(MAX_LEN)+1].
REQ-009 The block SHALL have ports beat_valid out 1, beat_ready in 1  beat handshake.
REQ-010 The block SHALL have port beat out ahb_beat_t  addr, write, trans (NONSEQ/SEQ), byte_sel, first, last.
REQ-011 The block SHALL have port busy out 1  queue non-empty or burst active.
REQ-012 The block SHALL have port err_len out 1  one-cycle pulse on accepting a request with len=0 or len>MAX_LEN.

Function
REQ-013 Requests SHALL transfer on req_valid&&req_ready; req_ready = queue not full.
REQ-014 Queue SHALL be FIFO order; simultaneous push and pop when full SHALL NOT be permitted (req_ready low when full, regardless of pop).
REQ-015 FSM states SHALL be IDLE and BURST; IDLE->BURST when queue non-empty (pop head same cycle); BURST->IDLE on last beat accepted with queue empty; BURST->BURST (pop next) on last beat accepted with queue non-empty, no bubble.
REQ-016 Latency SHALL be 1 cycle: request accepted at edge N into empty idle block gives beat_valid at N+1.
REQ-017 beat and beat_valid SHALL be registered and SHALL hold stable while beat_valid&&!beat_ready.
REQ-018 First beat SHALL carry addr=req.addr, trans=NONSEQ, first=1; subsequent beats trans=SEQ, first=0.
REQ-019 INCR mode: next addr = addr + BPB, modulo 2^ADDR_W.
REQ-020 WRAP mode: wrap boundary W = len*BPB; next addr = (addr & ~(W-1)) | ((addr+BPB) & (W-1)); if len not power of two, SHALL behave as INCR.
REQ-021 Beats per request SHALL equal len; last=1 on final beat; len=1 gives one beat with first=last=1.
REQ-022 len=0 or len>MAX_LEN SHALL be accepted, pulse err_len, and produce zero beats.
REQ-023 byte_sel and write (op==WRITE) SHALL be constant across all beats of a request; op==IDLE SHALL be treated as READ.
REQ-024 Unaligned addr (low log2(BPB) bits non-zero) SHALL be passed on the first beat; subsequent beats SHALL be aligned (low bits cleared before increment).
REQ-025 busy SHALL be high when queue non-empty or state==BURST.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, queue empty, beat_valid=0, req_ready=0 while rst_n low, busy=0, err_len=0, beat fields=0.
REQ-027 Reset mid-burst SHALL discard remaining beats and queued requests; no beat SHALL follow reset release until a new request.
REQ-028 req_ready SHALL rise the first clk edge after rst_n deasserts.

Structure
REQ-029 ahb_op_t, ahb_incr_type_t, ahb_trans_t, ahb_req_t, ahb_beat_t SHALL reside in shared package ahb_pkg, parametrised via package localparams matching defaults.
REQ-030 Queue SHALL be sub-module ahb_req_fifo (DEPTH, WIDTH), registered outputs, full/empty flags.
REQ-031 Address-next logic SHALL be a single function in ahb_pkg.

Verification
REQ-032 INCR len=4, addr=0x100, DATA_W=32 -> beats 0x100,0x104,0x108,0x10C; NONSEQ then SEQ; last on 4th.
REQ-033 WRAP len=4, addr=0x38 -> beats 0x38,0x3C,0x30,0x34; last on 0x34.
REQ-034 Two back-to-back requests len=2, beat_ready=1 -> 4 consecutive beat_valid cycles, no bubble, second NONSEQ at beat 3.
REQ-035 DEPTH+2 requests, beat_ready=0 -> req_ready low after DEPTH+1 accepted (DEPTH queued + 1 active); beat held stable throughout.
REQ-036 len=0 request -> err_len pulse, no beats; following len=1 request emits one beat first=last=1.
REQ-037 rst_n low at 2nd beat of len=8 burst -> beat_valid=0 immediately; no beats after release until new request.
